// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file write arbiter.
package regfile_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned NUM_REGS = 8;
   localparam logic [DATA_W-1:0] INIT_VALUE = 8'h00;

   typedef enum logic {ST_INIT, ST_ARB} state_e;

   typedef enum logic {RQ_ALU, RQ_MEM} req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant between ALU and MEM requesters.
// REGFILE_WRITE_ARB_FIXED_PRIO_EN selects fixed MEM-over-ALU priority instead of round-robin.
module rr_arb2 (
   input  logic CLK,
   input  logic RESET,
   input  logic EN,
   input  logic ALU_REQ,
   input  logic MEM_REQ,
   output logic ALU_GNT,
   output logic MEM_GNT
);

   import regfile_pkg::*;

`ifdef REGFILE_WRITE_ARB_FIXED_PRIO_EN
   // Load returns cannot be stalled by the cache, so MEM always wins.
   logic unused_clk_rst;
   assign unused_clk_rst = CLK ^ RESET;

   always_comb begin
      MEM_GNT = EN & MEM_REQ;
      ALU_GNT = EN & ALU_REQ & ~MEM_REQ;
   end
`else
   req_e last_q;

   always_comb begin
      ALU_GNT = EN & ALU_REQ & (~MEM_REQ | (last_q == RQ_MEM));
      MEM_GNT = EN & MEM_REQ & (~ALU_REQ | (last_q == RQ_ALU));
   end

   // Reset to MEM so the ALU is favoured on the first contended cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         last_q <= RQ_MEM;
      end else if (ALU_GNT) begin
         last_q <= RQ_ALU;
      end else if (MEM_GNT) begin
         last_q <= RQ_MEM;
      end
   end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: clears every register after reset, then arbitrates ALU/MEM.
// Define REGFILE_WRITE_ARB_FIXED_PRIO_EN for fixed MEM-over-ALU priority.
module regfile_write_arbiter #(
   parameter int unsigned       DATA_W     = regfile_pkg::DATA_W,
   parameter int unsigned       ADDR_W     = regfile_pkg::ADDR_W,
   parameter int unsigned       NUM_REGS   = regfile_pkg::NUM_REGS,
   parameter logic [DATA_W-1:0] INIT_VALUE = regfile_pkg::INIT_VALUE
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ALU_REQ,
   input  logic [ADDR_W-1:0] ALU_ADDR,
   input  logic [DATA_W-1:0] ALU_DATA,
   output logic              ALU_GNT,
   input  logic              MEM_REQ,
   input  logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [DATA_W-1:0] MEM_DATA,
   output logic              MEM_GNT,
   output logic              WRITE,
   output logic [ADDR_W-1:0] INADDRESS,
   output logic [DATA_W-1:0] IN,
   output logic              INIT_BUSY
);

   import regfile_pkg::*;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

   state_e            state_q;
   logic [ADDR_W:0]   cnt_q;
   logic              write_q;
   logic              busy_q;
   logic [ADDR_W-1:0] inaddr_q;
   logic [DATA_W-1:0] in_q;
   logic              arb_en;

   // State is forced to INIT while RESET is high, so both grants are low then too.
   assign arb_en = (state_q == ST_ARB);

   rr_arb2 u_arb (
      .CLK     (CLK),
      .RESET   (RESET),
      .EN      (arb_en),
      .ALU_REQ (ALU_REQ),
      .MEM_REQ (MEM_REQ),
      .ALU_GNT (ALU_GNT),
      .MEM_GNT (MEM_GNT)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         inaddr_q <= '0;
         in_q     <= '0;
         busy_q   <= 1'b1;
      end else begin
         // Lags the state by one edge so it drops with the last init write's WRITE.
         busy_q <= (state_q == ST_INIT);
         unique case (state_q)
            ST_INIT: begin
               write_q  <= 1'b1;
               inaddr_q <= cnt_q[ADDR_W-1:0];
               in_q     <= INIT_VALUE;
               cnt_q    <= cnt_q + CNT_ONE;
               if (cnt_q == LAST_IDX) begin
                  state_q <= ST_ARB;
               end
            end
            ST_ARB: begin
               write_q <= ALU_GNT | MEM_GNT;
               if (MEM_GNT) begin
                  inaddr_q <= MEM_ADDR;
                  in_q     <= MEM_DATA;
               end else if (ALU_GNT) begin
                  inaddr_q <= ALU_ADDR;
                  in_q     <= ALU_DATA;
               end
            end
         endcase
      end
   end

   assign WRITE     = write_q;
   assign INADDRESS = inaddr_q;
   assign IN        = in_q;
   assign INIT_BUSY = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_regfile_write_arbiter;

   import regfile_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned NR = 8;

`ifdef REGFILE_WRITE_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESET;
   logic          ALU_REQ, MEM_REQ;
   logic [AW-1:0] ALU_ADDR, MEM_ADDR;
   logic [DW-1:0] ALU_DATA, MEM_DATA;
   logic          ALU_GNT, MEM_GNT, WRITE, INIT_BUSY;
   logic [AW-1:0] INADDRESS;
   logic [DW-1:0] IN;

   regfile_write_arbiter dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .ALU_REQ   (ALU_REQ),
      .ALU_ADDR  (ALU_ADDR),
      .ALU_DATA  (ALU_DATA),
      .ALU_GNT   (ALU_GNT),
      .MEM_REQ   (MEM_REQ),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_DATA  (MEM_DATA),
      .MEM_GNT   (MEM_GNT),
      .WRITE     (WRITE),
      .INADDRESS (INADDRESS),
      .IN        (IN),
      .INIT_BUSY (INIT_BUSY)
   );

   always #5 CLK = ~CLK;

   // Register file driven by the DUT outputs; seeded with a non-init pattern.
   logic [DW-1:0] rf [NR];
   bit            rf_seed;
   always @(posedge CLK) begin
      if (rf_seed) begin
         for (int i = 0; i < NR; i++) rf[i] <= 8'hA5;
      end else if (WRITE) begin
         rf[INADDRESS] <= IN;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: edges since reset release, last winner, pending write, register contents.
   int            edges;
   bit            m_last_mem;
   bit            e_write;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_in;
   logic [DW-1:0] m_rf [NR];

   task automatic model_reset();
      edges      = 0;
      m_last_mem = 1'b1;
      e_write    = 1'b0;
      e_addr     = '0;
      e_in       = '0;
   endtask

   task automatic check_rf();
      for (int i = 0; i < NR; i++) check_eq($sformatf("r%0d", i), rf[i], m_rf[i]);
   endtask

   task automatic new_reqs();
      if (!ALU_REQ && $urandom_range(0, 99) < 55) begin
         ALU_REQ  = 1'b1;
         ALU_ADDR = AW'($urandom);
         ALU_DATA = DW'($urandom);
      end
      if (!MEM_REQ && $urandom_range(0, 99) < 55) begin
         MEM_REQ  = 1'b1;
         MEM_ADDR = AW'($urandom);
         MEM_DATA = DW'($urandom);
      end
   endtask

   // One clock cycle, entered and left at a negedge with inputs already driven.
   task automatic tick(input bit rnd);
      bit exp_ag, exp_mg;
      #1;
      exp_ag = 1'b0;
      exp_mg = 1'b0;
      if (edges >= NR) begin
         if (ALU_REQ && MEM_REQ) begin
            if (FIXED_PRIO || !m_last_mem) exp_mg = 1'b1;
            else                           exp_ag = 1'b1;
         end else begin
            exp_ag = ALU_REQ;
            exp_mg = MEM_REQ;
         end
      end
      check_eq("alu_gnt", ALU_GNT, exp_ag);
      check_eq("mem_gnt", MEM_GNT, exp_mg);
      @(posedge CLK);
      if (e_write) m_rf[e_addr] = e_in;
      if (edges < NR) begin
         e_write = 1'b1;
         e_addr  = AW'(edges);
         e_in    = INIT_VALUE;
      end else if (exp_mg) begin
         e_write    = 1'b1;
         e_addr     = MEM_ADDR;
         e_in       = MEM_DATA;
         m_last_mem = 1'b1;
      end else if (exp_ag) begin
         e_write    = 1'b1;
         e_addr     = ALU_ADDR;
         e_in       = ALU_DATA;
         m_last_mem = 1'b0;
      end else begin
         e_write = 1'b0;
      end
      edges++;
      #1;
      check_eq("write", WRITE, e_write);
      check_eq("inaddress", INADDRESS, e_addr);
      check_eq("in", IN, e_in);
      check_eq("init_busy", INIT_BUSY, edges <= NR);
      if (exp_ag) ALU_REQ = 1'b0;
      if (exp_mg) MEM_REQ = 1'b0;
      if (rnd) new_reqs();
      @(negedge CLK);
   endtask

   // Called at a negedge: holds RESET across one posedge, any pending write is lost.
   task automatic do_reset();
      RESET = 1'b1;
      #1;
      check_eq("rst_write", WRITE, 0);
      check_eq("rst_inaddress", INADDRESS, 0);
      check_eq("rst_in", IN, 0);
      check_eq("rst_busy", INIT_BUSY, 1);
      check_eq("rst_gnt", {ALU_GNT, MEM_GNT}, 0);
      model_reset();
      @(posedge CLK);
      #1;
      check_rf();
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      RESET    = 1'b1;
      rf_seed  = 1'b1;
      ALU_REQ  = 1'b0;
      MEM_REQ  = 1'b0;
      ALU_ADDR = '0;
      ALU_DATA = '0;
      MEM_ADDR = '0;
      MEM_DATA = '0;
      for (int i = 0; i < NR; i++) m_rf[i] = 8'hA5;
      model_reset();
      @(posedge CLK);
      #1;
      check_eq("rst_write", WRITE, 0);
      check_eq("rst_busy", INIT_BUSY, 1);
      check_eq("rst_gnt", {ALU_GNT, MEM_GNT}, 0);
      @(negedge CLK);
      rf_seed = 1'b0;
      RESET   = 1'b0;

      // Init sequence with no traffic.
      repeat (NR + 1) tick(1'b0);
      check_rf();

      // Single ALU write to r3.
      ALU_REQ = 1'b1; ALU_ADDR = 3'd3; ALU_DATA = 8'h2A;
      repeat (2) tick(1'b0);
      check_rf();
      check_eq("r3_final", rf[3], 8'h2A);

      // Same-address collision on r5 with LAST=ALU.
      ALU_REQ = 1'b1; ALU_ADDR = 3'd5; ALU_DATA = 8'h05;
      MEM_REQ = 1'b1; MEM_ADDR = 3'd5; MEM_DATA = 8'h50;
      repeat (3) tick(1'b0);
      check_rf();
      check_eq("r5_final", rf[5], 8'h05);

      // MEM solo write, then both contend on r1/r2.
      MEM_REQ = 1'b1; MEM_ADDR = 3'd0; MEM_DATA = 8'h99;
      tick(1'b0);
      ALU_REQ = 1'b1; ALU_ADDR = 3'd1; ALU_DATA = 8'h11;
      MEM_REQ = 1'b1; MEM_ADDR = 3'd2; MEM_DATA = 8'h22;
      repeat (3) tick(1'b0);
      check_rf();

      // Reset mid-init right after the r3 init write is registered.
      do_reset();
      repeat (4) tick(1'b0);
      do_reset();
      repeat (NR + 1) tick(1'b0);
      check_rf();

      // Reset while a granted ALU write is in flight, with another request pending.
      ALU_REQ = 1'b1; ALU_ADDR = 3'd6; ALU_DATA = 8'h77;
      tick(1'b0);
      ALU_REQ = 1'b1; ALU_ADDR = 3'd4; ALU_DATA = 8'h44;
      do_reset();

      // ALU_REQ held through init: granted in the first arbitration cycle.
      repeat (NR + 2) tick(1'b0);
      check_rf();
      check_eq("r4_final", rf[4], 8'h44);

      // Random traffic with one reset in the middle.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         tick(1'b1);
         if (i % 50 == 49) check_rf();
      end
      ALU_REQ = 1'b0;
      MEM_REQ = 1'b0;
      repeat (2) tick(1'b0);
      check_rf();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
